// File: rtl/pass_done_collector.sv
// Collects per-channel MTC0 pass/fail/done reports into sticky status, saturating
// counters and a round-robin-arbitrated event log FIFO.
module pass_done_collector #(
  parameter int unsigned N_CHAN = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clear,
  input  logic [N_CHAN-1:0]                           mtc0_valid,
  input  logic [2*N_CHAN-1:0]                         mtc0_code,
  output logic [N_CHAN-1:0]                           chan_done,
  output logic [N_CHAN-1:0]                           chan_fail,
  output logic                                        all_done,
  output logic                                        any_fail,
  output logic [CNT_W-1:0]                            pass_cnt,
  output logic [CNT_W-1:0]                            fail_cnt,
  output logic                                        log_overflow,
  output logic                                        evt_valid,
  input  logic                                        evt_ready,
  output logic [((N_CHAN > 1) ? $clog2(N_CHAN) : 1)-1:0] evt_chan,
  output logic [1:0]                                  evt_code
);

  localparam int unsigned CW   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned OCCW = AW + 1;
  localparam int unsigned SW   = CNT_W + 5;

  // MTC0Code encoding shared with the CPU side
  localparam logic [1:0] MTC0_NOOP = 2'd0;
  localparam logic [1:0] MTC0_PASS = 2'd1;
  localparam logic [1:0] MTC0_FAIL = 2'd2;
  localparam logic [1:0] MTC0_DONE = 2'd3;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FAILED = 2'd1, ST_DONE = 2'd2} state_e;

  logic   sclr;
  state_e state_q [N_CHAN];
  state_e state_d [N_CHAN];
  logic [N_CHAN-1:0] fail_seen_q, fail_seen_d;
  logic [1:0]        code_c [N_CHAN];
  logic [N_CHAN-1:0] acc;

  logic [N_CHAN-1:0] pend_v;
  logic [1:0]        pend_code [N_CHAN];
  logic [CW-1:0]     rr_ptr;
  logic [N_CHAN-1:0] gnt;
  logic [CW-1:0]     gnt_idx;
  logic [1:0]        gnt_code;
  logic              gnt_any;
  logic              drop_any;

  logic [CW-1:0]     mem_chan [DEPTH];
  logic [1:0]        mem_code [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [OCCW-1:0]   occ;
  logic              pop, push_ok;

  logic [4:0]        n_pass, n_fail;
  logic [SW-1:0]     pass_sum, fail_sum;

  assign sclr = rst | clear;

  // Event qualification: a channel that is already done ignores everything
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      code_c[i] = mtc0_code[2*i +: 2];
      acc[i]    = mtc0_valid[i] && (code_c[i] != MTC0_NOOP) && (state_q[i] != ST_DONE);
    end
  end

  // Channel FSM: state register
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < N_CHAN; i++) state_q[i] <= ST_RUN;
      fail_seen_q <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) state_q[i] <= state_d[i];
      fail_seen_q <= fail_seen_d;
    end
  end

  // Channel FSM: next state
  always_comb begin
    fail_seen_d = fail_seen_q;
    for (int i = 0; i < N_CHAN; i++) begin
      state_d[i] = state_q[i];
      if (acc[i]) begin
        case (code_c[i])
          MTC0_FAIL: begin
            state_d[i]     = ST_FAILED;
            fail_seen_d[i] = 1'b1;
          end
          MTC0_DONE: state_d[i] = ST_DONE;
          default: ;
        endcase
      end
    end
  end

  // Channel FSM: outputs
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) chan_done[i] = (state_q[i] == ST_DONE);
    chan_fail = fail_seen_q;
    all_done  = &chan_done;
    any_fail  = |chan_fail;
  end

  // Saturating aggregate counters
  always_comb begin
    n_pass = '0;
    n_fail = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      n_pass = n_pass + 5'(acc[i] && (code_c[i] == MTC0_PASS));
      n_fail = n_fail + 5'(acc[i] && (code_c[i] == MTC0_FAIL));
    end
    pass_sum = SW'(pass_cnt) + SW'(n_pass);
    fail_sum = SW'(fail_cnt) + SW'(n_fail);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      pass_cnt <= (pass_sum[SW-1:CNT_W] != '0) ? '1 : pass_sum[CNT_W-1:0];
      fail_cnt <= (fail_sum[SW-1:CNT_W] != '0) ? '1 : fail_sum[CNT_W-1:0];
    end
  end

  assign evt_valid = (occ != '0);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = (occ < OCCW'(DEPTH)) || pop;

  // Round-robin grant: search outward from rr_ptr for the first pending channel
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_code = MTC0_NOOP;
    gnt_any  = 1'b0;
    for (int unsigned k = 0; k < N_CHAN; k++) begin
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (!gnt_any && push_ok && pend_v[i] && (((32'(rr_ptr) + k) % N_CHAN) == i)) begin
          gnt_any  = 1'b1;
          gnt[i]   = 1'b1;
          gnt_idx  = CW'(i);
          gnt_code = pend_code[i];
        end
      end
    end
    drop_any = |(acc & pend_v & ~gnt);
  end

  // Pending slots; a slot granted this cycle may be refilled without loss
  always_ff @(posedge clk) begin
    if (sclr) begin
      pend_v       <= '0;
      rr_ptr       <= '0;
      log_overflow <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) pend_code[i] <= MTC0_NOOP;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (acc[i]) begin
          if (!pend_v[i] || gnt[i]) begin
            pend_v[i]    <= 1'b1;
            pend_code[i] <= code_c[i];
          end
        end else if (gnt[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      if (gnt_any) rr_ptr <= (gnt_idx == CW'(N_CHAN - 1)) ? '0 : gnt_idx + CW'(1);
      log_overflow <= log_overflow | drop_any;
    end
  end

  // Log FIFO storage; contents are don't-care outside the valid window
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      mem_chan[wr_ptr] <= gnt_idx;
      mem_code[wr_ptr] <= gnt_code;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (gnt_any) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OCCW'(gnt_any) - OCCW'(pop);
    end
  end

  assign evt_chan = mem_chan[rd_ptr];
  assign evt_code = mem_code[rd_ptr];

endmodule

// File: tb/tb_pass_done_collector.sv
// Directed self-checking bench for pass_done_collector (N_CHAN=4, DEPTH=4, CNT_W=4).
module tb_pass_done_collector;

  localparam logic [1:0] NOOP = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] FAIL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic       clk = 1'b0;
  logic       rst, clear, evt_ready;
  logic [3:0] mtc0_valid;
  logic [7:0] mtc0_code;
  logic [3:0] chan_done, chan_fail;
  logic       all_done, any_fail, log_overflow, evt_valid;
  logic [3:0] pass_cnt, fail_cnt;
  logic [1:0] evt_chan, evt_code;

  int n_cmp = 0;
  int n_bad = 0;

  pass_done_collector #(.N_CHAN(4), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .mtc0_valid(mtc0_valid), .mtc0_code(mtc0_code),
    .chan_done(chan_done), .chan_fail(chan_fail),
    .all_done(all_done), .any_fail(any_fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .log_overflow(log_overflow),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_chan(evt_chan), .evt_code(evt_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [1:0] c0, input logic [1:0] c1,
                       input logic [1:0] c2, input logic [1:0] c3);
    mtc0_valid = v;
    mtc0_code  = {c3, c2, c1, c0};
  endtask

  task automatic idle();
    drive(4'b0000, NOOP, NOOP, NOOP, NOOP);
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; evt_ready = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_done", 32'(chan_done), 0);
    chk("rst_cnts", 32'({pass_cnt, fail_cnt}), 0);

    // ch1 PASS, PASS, DONE with a free-running consumer
    drive(4'b0010, NOOP, PASS, NOOP, NOOP);
    tick();
    chk("a_pcnt1", 32'(pass_cnt), 1);
    chk("a_lat1", 32'(evt_valid), 0);
    drive(4'b0010, NOOP, PASS, NOOP, NOOP);
    tick();
    chk("a_lat2", 32'(evt_valid), 1);
    chk("a_head0", 32'({evt_chan, evt_code}), 32'({2'd1, PASS}));
    chk("a_pcnt2", 32'(pass_cnt), 2);
    drive(4'b0010, NOOP, DONE, NOOP, NOOP);
    tick();
    chk("a_done", 32'(chan_done), 32'(4'b0010));
    chk("a_head1", 32'({evt_valid, evt_chan, evt_code}), 32'({1'b1, 2'd1, PASS}));
    idle();
    tick();
    chk("a_head2", 32'({evt_valid, evt_chan, evt_code}), 32'({1'b1, 2'd1, DONE}));
    chk("a_pcnt3", 32'(pass_cnt), 2);
    tick();
    chk("a_empty", 32'(evt_valid), 0);
    chk("a_alldone", 32'(all_done), 0);

    // Simultaneous FAIL on all channels, twice
    do_clear();
    for (int b = 0; b < 2; b++) begin
      drive(4'b1111, FAIL, FAIL, FAIL, FAIL);
      tick();
      chk("b_fcnt", 32'(fail_cnt), 32'(4 * (b + 1)));
      chk("b_anyfail", 32'(any_fail), 1);
      chk("b_chfail", 32'(chan_fail), 32'(4'b1111));
      idle();
      tick();
      for (int c = 0; c < 4; c++) begin
        chk("b_order", 32'({evt_valid, evt_chan, evt_code}), 32'({1'b1, 2'(c), FAIL}));
        tick();
      end
      chk("b_empty", 32'(evt_valid), 0);
    end

    // Stalled consumer, six back-to-back PASS on ch0
    do_clear();
    evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, PASS, NOOP, NOOP, NOOP);
      tick();
    end
    idle();
    chk("c_pcnt", 32'(pass_cnt), 6);
    chk("c_ovf", 32'(log_overflow), 1);
    chk("c_head", 32'({evt_valid, evt_chan, evt_code}), 32'({1'b1, 2'd0, PASS}));
    tick();
    chk("c_hold", 32'({evt_valid, evt_chan, evt_code}), 32'({1'b1, 2'd0, PASS}));
    chk("c_full", 32'(dut.occ), 4);
    evt_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("c_last", 32'(evt_valid), 1);
    tick();
    chk("c_drained", 32'(evt_valid), 0);
    chk("c_ovf_sticky", 32'(log_overflow), 1);

    // Events after DONE are ignored
    do_clear();
    drive(4'b0100, NOOP, NOOP, DONE, NOOP);
    tick();
    chk("d_done", 32'(chan_done), 32'(4'b0100));
    drive(4'b0100, NOOP, NOOP, PASS, NOOP);
    tick();
    chk("d_head", 32'({evt_valid, evt_chan, evt_code}), 32'({1'b1, 2'd2, DONE}));
    chk("d_pcnt", 32'(pass_cnt), 0);
    idle();
    tick();
    chk("d_nolog", 32'(evt_valid), 0);
    chk("d_pcnt2", 32'(pass_cnt), 0);
    drive(4'b1111, DONE, DONE, DONE, DONE);
    tick();
    idle();
    chk("d_alldone", 32'({all_done, chan_done}), 32'({1'b1, 4'b1111}));
    chk("d_nofail", 32'(any_fail), 0);

    // Saturation after 17 PASS on ch3
    do_clear();
    for (int k = 0; k < 17; k++) begin
      drive(4'b1000, NOOP, NOOP, NOOP, PASS);
      tick();
    end
    idle();
    chk("e_sat", 32'(pass_cnt), 15);

    // clear beats a concurrent FAIL while the log holds three entries
    do_clear();
    evt_ready = 1'b0;
    drive(4'b1110, NOOP, FAIL, FAIL, FAIL);
    tick();
    idle();
    tick(); tick(); tick();
    chk("f_pre", 32'({evt_valid, evt_chan}), 32'({1'b1, 2'd1}));
    chk("f_pre_occ", 32'(dut.occ), 3);
    drive(4'b0001, FAIL, NOOP, NOOP, NOOP);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    chk("f_valid", 32'(evt_valid), 0);
    chk("f_cnts", 32'({pass_cnt, fail_cnt}), 0);
    chk("f_status", 32'({chan_done, chan_fail, all_done, any_fail, log_overflow}), 0);
    tick();
    chk("f_after", 32'({evt_valid, fail_cnt, chan_fail}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
